// File: rtl/if_fetch_queue.sv
// In-order fetch queue between the I-cache response side of pre-fetch and ID.
// Each accepted request allocates an entry at the tail; I-cache responses
// fill the oldest pending entry; filled entries leave in order through a
// valid/ready handshake.
//
// Handshake: the head entry is transferred to ID on a cycle where
// out_valid && out_ready are both high at the rising clock edge. out_valid
// never depends on out_ready. The pre-fetch side may assert req_fire only in
// a cycle where can_issue is high.
//
// On flush, queued entries are discarded and drop_cnt remembers how many
// responses are still owed for discarded requests, so those late words can
// be swallowed without touching the new path.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 19
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_fire,
  input  logic [31:0]                req_pc,
  input  logic [EXC_W-1:0]           req_except,
  input  logic                       rsp_valid,
  input  logic [31:0]                rsp_data,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [EXC_W-1:0]           out_except,
  output logic                       can_issue,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW+1:0] DEPTH_X = (OW+2)'(DEPTH);

  logic [31:0]      pc_q    [DEPTH];
  logic [EXC_W-1:0] exc_q   [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] pending_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    drop_q;

  logic             push;
  logic             pop;
  logic             fill;
  logic             fill_hit;
  logic [PW-1:0]    fill_idx;
  logic [PW-1:0]    scan;
  logic [OW+1:0]    pend_cnt;
  logic             new_pend;
  logic [OW+1:0]    drop_sum;
  logic [OW-1:0]    drop_next;

  // Head entry drives ID directly from flops; can_issue sees registers only.
  assign out_valid  = valid_q[head_q] & ~pending_q[head_q];
  assign out_pc     = pc_q[head_q];
  assign out_instr  = instr_q[head_q];
  assign out_except = exc_q[head_q];
  assign occupancy  = occ_q;
  assign can_issue  = ({2'b00, occ_q} + {2'b00, drop_q}) < DEPTH_X;

  assign push = req_fire & can_issue & ~flush;
  assign pop  = out_valid & out_ready & ~flush;
  assign fill = rsp_valid & (drop_q == '0) & fill_hit & ~flush;

  // Find the oldest pending entry (search from head, wrapping) and count pending entries.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head_q;
    scan     = head_q;
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan = head_q + PW'(i);
      if (pending_q[scan] && !fill_hit) begin
        fill_hit = 1'b1;
        fill_idx = scan;
      end
      pend_cnt = pend_cnt + (OW+2)'(pending_q[i]);
    end
  end

  // Responses owed to discarded requests: accumulate on flush, drain on each response.
  always_comb begin
    new_pend  = req_fire & can_issue & (req_except == '0);
    drop_sum  = {2'b00, drop_q} + pend_cnt + (OW+2)'(new_pend);
    if (rsp_valid && drop_sum != '0) begin
      drop_sum = drop_sum - (OW+2)'(1);
    end
    drop_next = drop_q;
    if (flush) begin
      drop_next = (drop_sum > DEPTH_X) ? OW'(DEPTH) : drop_sum[OW-1:0];
    end else if (rsp_valid && drop_q != '0) begin
      drop_next = drop_q - OW'(1);
    end
  end

  // Entry array, pointers and counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        exc_q[i]   <= '0;
        instr_q[i] <= '0;
      end
      valid_q   <= '0;
      pending_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      drop_q    <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        exc_q[i]   <= '0;
        instr_q[i] <= '0;
      end
      valid_q   <= '0;
      pending_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      drop_q    <= drop_next;
    end else begin
      // A fill targets a pending entry, a pop a filled head, a push a free
      // slot, so the three never touch the same index in one cycle.
      if (fill) begin
        instr_q[fill_idx]   <= rsp_data;
        pending_q[fill_idx] <= 1'b0;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        pc_q[head_q]    <= '0;
        exc_q[head_q]   <= '0;
        instr_q[head_q] <= '0;
        head_q          <= head_q + PW'(1);
      end
      if (push) begin
        pc_q[tail_q]      <= req_pc;
        exc_q[tail_q]     <= req_except;
        instr_q[tail_q]   <= '0;
        valid_q[tail_q]   <= 1'b1;
        pending_q[tail_q] <= (req_except == '0);
        tail_q            <= tail_q + PW'(1);
      end
      occ_q  <= occ_q + OW'(push) - OW'(pop);
      drop_q <= drop_next;
    end
  end

  // Protocol checks on the neighbouring stages.
  a_issue_allowed: assert property (@(posedge clk) disable iff (!resetn)
    req_fire |-> can_issue);
  a_rsp_expected: assert property (@(posedge clk) disable iff (!resetn)
    rsp_valid |-> (drop_q != '0 || fill_hit));
  a_drop_bound: assert property (@(posedge clk) disable iff (!resetn)
    flush |-> (drop_sum <= DEPTH_X));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the fetch queue.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int EXC_W = 19;

  logic             clk;
  logic             resetn;
  logic             req_fire;
  logic [31:0]      req_pc;
  logic [EXC_W-1:0] req_except;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [EXC_W-1:0] out_except;
  logic             can_issue;
  logic [2:0]       occupancy;

  if_fetch_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_fire   (req_fire),
    .req_pc     (req_pc),
    .req_except (req_except),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_except (out_except),
    .can_issue  (can_issue),
    .occupancy  (occupancy)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of live entries plus the count of owed responses.
  typedef struct {
    logic [31:0]      pc;
    logic [EXC_W-1:0] exc;
    logic [31:0]      instr;
    bit               filled;
  } ent_t;

  ent_t        mq[$];
  int          drop_m;
  logic [63:0] exp_q[$];
  int          checks;
  int          errors;
  int          dut_pops;
  int          model_pops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_can_issue();
    return (mq.size() + drop_m) < DEPTH;
  endfunction

  function automatic bit model_has_unfilled();
    foreach (mq[i]) if (!mq[i].filled) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    bit exp_v;
    exp_v = (mq.size() > 0) && mq[0].filled;
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("can_issue", 64'(can_issue), 64'(model_can_issue()));
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    if (exp_v) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
      chk("out_except", 64'(out_except), 64'(mq[0].exc));
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_update();
    bit   can_m;
    bit   pop_m;
    bit   push_m;
    bit   done;
    int   pend;
    int   s;
    ent_t e;
    can_m  = model_can_issue();
    pop_m  = !flush && mq.size() > 0 && mq[0].filled && out_ready;
    push_m = req_fire && can_m && !flush;
    if (flush) begin
      pend = 0;
      foreach (mq[i]) if (!mq[i].filled) pend++;
      s = drop_m + pend + ((req_fire && can_m && req_except == '0) ? 1 : 0);
      if (rsp_valid && s > 0) s--;
      drop_m = (s > DEPTH) ? DEPTH : s;
      mq.delete();
    end else begin
      if (rsp_valid) begin
        if (drop_m > 0) begin
          drop_m--;
        end else begin
          done = 1'b0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled && !done) begin
              mq[i].instr  = rsp_data;
              mq[i].filled = 1'b1;
              done = 1'b1;
            end
          end
        end
      end
      if (pop_m) begin
        exp_q.push_back({mq[0].pc, mq[0].instr});
        model_pops++;
        void'(mq.pop_front());
      end
      if (push_m) begin
        e.pc     = req_pc;
        e.exc    = req_except;
        e.instr  = '0;
        e.filled = (req_except != '0);
        mq.push_back(e);
      end
    end
  endtask

  // One clock: compare, score any transfer to ID, advance model, step past the edge.
  task automatic step();
    bit          dut_pop;
    logic [63:0] pair;
    logic [63:0] exp_pair;
    check_outputs();
    dut_pop = out_valid && out_ready && !flush;
    pair    = {out_pc, out_instr};
    model_update();
    if (dut_pop) begin
      dut_pops++;
      exp_pair = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      chk("pop_pair", pair, exp_pair);
    end
    chk("pop_count", 64'(dut_pops), 64'(model_pops));
    @(posedge clk);
    #1;
  endtask

  // Driver: set every input for one cycle, then step.
  task automatic cyc(input bit f, input logic [31:0] pc, input logic [EXC_W-1:0] exc,
                     input bit r, input logic [31:0] d, input bit fl, input bit rdy);
    req_fire   = f;
    req_pc     = pc;
    req_except = exc;
    rsp_valid  = r;
    rsp_data   = d;
    flush      = fl;
    out_ready  = rdy;
    step();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, '0, 0, 32'h0, 0, rdy);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    drop_m     = 0;
    dut_pops   = 0;
    model_pops = 0;
  endtask

  initial begin
    int p0;
    bit f;
    bit r;
    logic [EXC_W-1:0] exc;
    checks = 0;
    errors = 0;
    model_reset();
    resetn     = 1'b0;
    req_fire   = 1'b0;
    req_pc     = '0;
    req_except = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_can_issue", 64'(can_issue), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_except", 64'(out_except), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic ordering.
    p0 = dut_pops;
    cyc(1, 32'hBFC0_0000, '0, 0, 32'h0,  0, 1);
    cyc(1, 32'hBFC0_0004, '0, 1, 32'h11, 0, 1);
    cyc(1, 32'hBFC0_0008, '0, 1, 32'h22, 0, 1);
    cyc(0, 32'h0,         '0, 1, 32'h33, 0, 1);
    idle(3, 1);
    chk("basic_pops", 64'(dut_pops - p0), 64'd3);

    // Exception entry waits behind a late-filled head.
    p0 = dut_pops;
    cyc(1, 32'h1000, '0,            0, 32'h0,  0, 1);
    cyc(1, 32'h1004, 19'h0_0100,    0, 32'h0,  0, 1);
    cyc(0, 32'h0,    '0,            0, 32'h0,  0, 1);
    cyc(0, 32'h0,    '0,            1, 32'hAA, 0, 1);
    idle(3, 1);
    chk("exc_pops", 64'(dut_pops - p0), 64'd2);

    // Full / back-pressure.
    p0 = dut_pops;
    cyc(1, 32'h100, '0, 0, 32'h0,  0, 0);
    cyc(1, 32'h104, '0, 1, 32'hA1, 0, 0);
    cyc(1, 32'h108, '0, 1, 32'hA2, 0, 0);
    cyc(1, 32'h10C, '0, 1, 32'hA3, 0, 0);
    cyc(0, 32'h0,   '0, 1, 32'hA4, 0, 0);
    chk("full_occupancy", 64'(occupancy), 64'd4);
    chk("full_can_issue", 64'(can_issue), 64'd0);
    idle(1, 1);
    chk("pop1_occupancy", 64'(occupancy), 64'd3);
    chk("pop1_can_issue", 64'(can_issue), 64'd1);
    idle(4, 1);
    chk("full_pops", 64'(dut_pops - p0), 64'd4);

    // Flush with two responses still in flight.
    p0 = dut_pops;
    cyc(1, 32'h3000, '0, 0, 32'h0, 0, 1);
    cyc(1, 32'h3004, '0, 0, 32'h0, 0, 1);
    cyc(0, 32'h0,    '0, 0, 32'h0, 1, 1);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_can_issue", 64'(can_issue), 64'd1);
    cyc(0, 32'h0,    '0, 1, 32'hDEAD, 0, 1);
    cyc(0, 32'h0,    '0, 1, 32'hBEEF, 0, 1);
    cyc(1, 32'h2000, '0, 0, 32'h0,    0, 1);
    cyc(0, 32'h0,    '0, 1, 32'h55,   0, 1);
    idle(2, 1);
    chk("flush_pops", 64'(dut_pops - p0), 64'd1);

    // Flush, request and response in the same cycle: one response becomes owed.
    cyc(1, 32'h4000, '0, 0, 32'h0,  0, 1);
    cyc(1, 32'h4004, '0, 1, 32'h77, 1, 1);
    chk("simul_occupancy", 64'(occupancy), 64'd0);
    chk("simul_out_valid", 64'(out_valid), 64'd0);
    cyc(1, 32'h5000, '0, 0, 32'h0, 0, 0);
    cyc(1, 32'h5004, '0, 0, 32'h0, 0, 0);
    cyc(1, 32'h5008, '0, 0, 32'h0, 0, 0);
    chk("owed_occupancy", 64'(occupancy), 64'd3);
    chk("owed_can_issue", 64'(can_issue), 64'd0);

    // Asynchronous reset mid-stream, observed before any clock edge.
    req_fire  = 1'b0;
    rsp_valid = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_can_issue", 64'(can_issue), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Random legal traffic.
    for (int n = 0; n < 800; n++) begin
      f   = model_can_issue() && ($urandom_range(0, 2) != 0);
      exc = ($urandom_range(0, 5) == 0) ? (EXC_W'(1) << $urandom_range(0, EXC_W-1)) : '0;
      r   = (drop_m > 0 || model_has_unfilled()) && ($urandom_range(0, 1) == 1);
      cyc(f, $urandom & 32'hFFFF_FFFC, exc, r, $urandom,
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

- In-order fetch queue between the instruction-cache response side of the pre-fetch stage and the decode stage.
- On each accepted fetch request it allocates an entry holding the PC and the fetch exception vector. Instruction-cache responses fill the oldest pending entry, and filled entries are presented in order to ID through a valid/ready handshake.
- On a pipeline flush it discards all queued entries and silently drops responses still in flight for discarded requests.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; a power of two, at least 2.
- EXC_W, 19, width of the fetch exception vector.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- req_fire  in  1  a fetch request was accepted this cycle.
- req_pc  in  32  PC of the accepted request.
- req_except  in  EXC_W  exception vector of the request.
  - Nonzero means no cache response will come.
- rsp_valid  in  1  instruction-cache returns one word this cycle.
- rsp_data  in  32  returned instruction word.
- flush  in  1  discard all in-flight and queued fetches.
- out_ready  in  1  ID accepts the head entry.
- out_valid  out  1  head entry is filled and presentable.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
  - 0 for exception entries.
- out_except  out  EXC_W  exception vector of the head entry.
- can_issue  out  1  pre-fetch stage may issue one request this cycle.
- occupancy  out  $clog2(DEPTH+1)  number of live entries.

## Operation
- Each entry holds: pc, except, instr, valid, pending.
- Allocation on req_fire:
  - The entry is written at the tail, valid=1, and the tail advances.
  - pending = (req_except == 0).
  - If req_except != 0, the entry is born filled with instr=0.
- Response on rsp_valid:
  - If drop_cnt > 0, drop_cnt decrements and rsp_data is discarded.
  - Otherwise rsp_data is written to the oldest entry with pending=1, and that entry's pending is cleared. The search starts at the head and wraps modulo DEPTH.
  - Responses never fill an entry allocated in the same cycle.
- Output:
  - The head is presentable when valid=1 and pending=0.
  - On out_valid && out_ready the head entry is cleared and the head advances.
- Flush:
  - All entries are cleared and the head, tail and occupancy are set to 0.
  - drop_cnt_next = drop_cnt + (number of live pending entries) + req_fire·(req_except==0) − rsp_valid.
  - A req_fire in the flush cycle is treated as old-path and is dropped.
  - A pop in the flush cycle is suppressed.
- can_issue = (occupancy + drop_cnt) < DEPTH.
  - This is combinational from registers only, with no path from inputs.
- Protocol errors:
  - req_fire while can_issue=0: assertion; the queue state is unchanged.
  - rsp_valid with no pending entry and drop_cnt=0: assertion; the word is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. occupancy and drop_cnt saturate at DEPTH; exceeding DEPTH is an assertion.

## Timing
- Reset, asynchronous:
  - All entries are invalid; head, tail, occupancy and drop_cnt are 0.
  - out_valid=0; out_pc, out_instr and out_except are 0.
  - can_issue=1.
- Reset mid-operation clears everything immediately, including drop_cnt, so late responses after reset are protocol errors.
- Latency:
  - A request allocated at cycle t with a response at t+k (k≥1) gives out_valid at t+k+1 when the entry is at the head.
  - An exception entry allocated at t gives out_valid at t+1.
- Outputs are registered from entry state: out_* is read from the head entry combinationally off flops, with no input-to-output path.
- Same-cycle push and pop are allowed at any occupancy that passed can_issue. occupancy_next = occupancy + push − pop.
- A response filling the head in the same cycle as a pop of the previous head is legal; the new head shows valid the next cycle.
- Throughput is one request, one response and one pop per cycle sustained.

## Test plan
- Basic ordering:
  - Stimulus: reset; fire 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; responses 0x11, 0x22, 0x33 one cycle later each; out_ready=1.
  - Required: out emits (pc, instr) pairs in order starting 2 cycles after the first fire, with out_except=0.
- Exception entry:
  - Stimulus: fire 0x1000 normally; next cycle fire 0x1004 with req_except bit 8 set; response 0xAA for 0x1000 arrives late at t+3.
  - Required: 0x1000/0xAA is emitted first, then 0x1004 with instr=0 and except bit 8 set. The exception entry waits behind the head.
- Full / back-pressure:
  - Stimulus: out_ready=0; fire 4 requests and respond to all.
  - Required: can_issue=0 and occupancy=4. After one pop, can_issue=1 in the same cycle as occupancy=3.
- Flush with in-flight responses:
  - Stimulus: fire 2 requests; flush before any response; then 2 responses, then a new fire 0x2000 with response 0x55.
  - Required: drop_cnt=2 after flush, and can_issue reflects occupancy+2. Both old responses are discarded; only 0x2000/0x55 is emitted.
- Simultaneous events:
  - Stimulus: flush, req_fire and rsp_valid in the same cycle, with one pending live entry and drop_cnt=0.
  - Required: drop_cnt becomes 1 (1 + 1 − 1) and the queue is empty with out_valid=0.
- Reset mid-stream:
  - Stimulus: assert resetn=0 asynchronously with 3 entries and drop_cnt=1.
  - Required: out_valid=0, occupancy=0 and can_issue=1 immediately, with no clock edge required.
